water_safety_multizone_ctrl: RTL and testbench
==============================================

Name: water_safety_multizone_ctrl

Overview:
- Multi-zone successor to the single-channel water safety FSM: N_CH independent valve channels.
- Shared Wi-Fi link status plus a per-zone flow sensor per channel.
- Adds per-channel flow debouncing, an enable mask, a maximum-ON watchdog with a sticky FAULT state, software fault clear, and aggregate status.
- Sits between the sensor-input synchroniser stage and the valve driver / status reporting logic.

Parameters:
- N_CH, 4, number of independent zones/channels (>=1).
- DEBOUNCE_CYC, 3, consecutive differing samples needed to accept a flow change (>=1).
- MAX_ON_CYC, 1000, maximum cycles a channel may stay ON before FAULT; 0 disables the watchdog.
- CW, $clog2(max(DEBOUNCE_CYC,MAX_ON_CYC)+1), internal counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in1  input  1  Wi-Fi link status, shared by all channels (1 = link up); already synchronous to clk
- in2  input  N_CH  raw flow status per channel (1 = flow detected); already synchronous to clk
- enable  input  N_CH  per-channel enable; 0 forces the channel out of ON
- clear_fault  input  N_CH  per-channel fault clear, level-sampled
- state_on  output  N_CH  1 = channel in ON state (registered)
- fault  output  N_CH  1 = channel in FAULT state (registered)
- trip_pulse  output  N_CH  one-cycle pulse per OFF->ON entry (registered)
- any_fault  output  1  OR-reduction of fault
- active_count  output  $clog2(N_CH+1)  number of channels with state_on=1

Behaviour:
- Reset:
  - Applied on a rising clk edge while reset=1.
  - All channels go to OFF; debounced flow = 0; all counters = 0.
  - state_on, fault, trip_pulse = 0; any_fault = 0; active_count = 0.
  - Reset overrides every other input, including mid-ON and mid-FAULT.
- Debounce, per channel:
  - Registered flow_db, with a counter dcnt.
  - If in2[i]==flow_db: dcnt<=0.
  - Otherwise dcnt increments. On the DEBOUNCE_CYC-th consecutive edge sampling in2[i]!=flow_db, flow_db toggles and dcnt<=0.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes flow_db.
  - With DEBOUNCE_CYC=1, flow_db is a one-cycle register of in2[i].
- Per-channel FSM, states OFF/ON/FAULT. Next state is evaluated from the current state, in1 (unregistered), flow_db, enable and clear_fault; updated each edge.
  - OFF -> ON when enable[i]=1 && in1=0 && flow_db=1. Otherwise stays OFF.
  - ON -> OFF when in1=1 && flow_db=1 (exit condition), or when enable[i]=0.
  - ON -> FAULT when MAX_ON_CYC!=0, ON has lasted MAX_ON_CYC cycles and no OFF condition holds on that edge. On that edge, the OFF condition has priority over the watchdog.
  - ON otherwise stays ON.
  - FAULT -> OFF when clear_fault[i]=1. Otherwise FAULT is sticky; enable has no effect in FAULT.
  - Unused encodings go to OFF.
  - clear_fault in OFF/ON has no effect.
- Watchdog counter ocnt:
  - Cleared on every edge entering ON; increments on each edge while remaining ON.
  - The transition to FAULT occurs on the MAX_ON_CYC-th edge after entry, so state_on is high for exactly MAX_ON_CYC cycles.
  - ocnt saturates; it never wraps.
- Outputs:
  - state_on[i]=(state==ON); fault[i]=(state==FAULT).
  - trip_pulse[i]=1 for exactly the first cycle state_on[i] is 1 after an OFF->ON edge, and 0 otherwise, including after FAULT->OFF.
  - A re-entry to ON immediately after exiting produces a new pulse.
- Aggregates:
  - any_fault and active_count are combinational from the state registers, so they are coincident with state_on/fault.
  - active_count is the population count of state_on.
- Channel independence: channels share only in1. Simultaneous events on different channels are handled independently in the same cycle.

Test Plan:
N_CH=4, DEBOUNCE_CYC=3, MAX_ON_CYC=8.
- Reset behaviour: assert reset for 2 cycles with all inputs high -> all outputs 0. Release -> flow_db needs 3 edges, so state_on stays 0 through edge 3.
- Trip: in1=0, enable=4'hF, in2[0] rises before edge 1 and holds.
  - flow_db[0]=1 after edge 3; state_on=4'b0001 after edge 4.
  - trip_pulse=4'b0001 for that single cycle only; active_count=1.
- Glitch rejection: in2[1] high for 2 cycles then low, in1=0 -> state_on[1], trip_pulse[1] never assert.
- Exit vs watchdog: channel 0 ON; set in1=1 on the edge where ocnt would hit 8 -> state_on[0]=0, fault[0]=0. Repeat with in1=0 held:
  - state_on[0] is high exactly 8 cycles, then fault[0]=1 and any_fault=1.
  - enable[0]=0 does not clear it; clear_fault[0]=1 for 1 cycle -> OFF next edge.
  - Re-trips with a new trip_pulse if in1=0 and flow_db=1.
- Enable / multi-channel: channels 0-3 all ON (active_count=4) -> drop enable[2] -> next edge state_on=4'b1011, active_count=3, no fault.
- Reset mid-FAULT: channel 3 in FAULT, assert reset 1 cycle -> fault=0, any_fault=0. A re-trip requires 3 fresh debounce edges.

Source files
------------

// File: rtl/water_safety_multizone_ctrl.sv
// Multi-zone water safety controller.
// N_CH independent valve channels share the Wi-Fi link status (in1). Each
// channel debounces its own flow sensor, runs an OFF/ON/FAULT state machine
// with an enable mask, and has a maximum-ON watchdog that latches FAULT until
// software clears it.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_OFF   | valve closed, waiting for enable && link down && flow
//   ST_ON    | valve driven, watchdog counting cycles spent ON
//   ST_FAULT | watchdog expired; sticky until clear_fault for the channel

module water_safety_multizone_ctrl #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 3,
    parameter int MAX_ON_CYC   = 1000,
    localparam int CNT_MAX     = (DEBOUNCE_CYC > MAX_ON_CYC) ? DEBOUNCE_CYC : MAX_ON_CYC,
    localparam int CW          = $clog2(CNT_MAX + 1),
    localparam int ACW         = $clog2(N_CH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in1,
    input  logic [N_CH-1:0] in2,
    input  logic [N_CH-1:0] enable,
    input  logic [N_CH-1:0] clear_fault,
    output logic [N_CH-1:0] state_on,
    output logic [N_CH-1:0] fault,
    output logic [N_CH-1:0] trip_pulse,
    output logic            any_fault,
    output logic [ACW-1:0]  active_count
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_FAULT = 2'b10
    } ch_state_t;

    // Terminal counts. The watchdog fires when ocnt has reached MAX_ON_CYC-1,
    // i.e. on the MAX_ON_CYC-th edge after entering ON.
    localparam logic [CW-1:0] DCNT_TC  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] OCNT_TC  = CW'((MAX_ON_CYC > 0) ? (MAX_ON_CYC - 1) : 0);
    localparam logic [CW-1:0] OCNT_SAT = {CW{1'b1}};
    localparam bit            WD_EN    = (MAX_ON_CYC != 0);

    ch_state_t       state_q   [N_CH];
    ch_state_t       state_nxt [N_CH];
    logic [CW-1:0]   dcnt_q    [N_CH];
    logic [CW-1:0]   ocnt_q    [N_CH];
    logic [N_CH-1:0] flow_db_q;
    logic [N_CH-1:0] trip_q;
    logic [N_CH-1:0] wd_expired;

    // Flow debounce: accept a new level only after DEBOUNCE_CYC consecutive
    // differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            flow_db_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (in2[i] == flow_db_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DCNT_TC) begin
                    flow_db_q[i] <= ~flow_db_q[i];
                    dcnt_q[i]    <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Watchdog terminal-count compare, gated off entirely when MAX_ON_CYC is 0.
    always_comb begin
        wd_expired = '0;
        for (int i = 0; i < N_CH; i++) begin
            wd_expired[i] = WD_EN && (ocnt_q[i] == OCNT_TC);
        end
    end

    // Next-state logic per channel; the OFF condition outranks the watchdog.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = ST_OFF;
            case (state_q[i])
                ST_OFF: begin
                    if (enable[i] && !in1 && flow_db_q[i]) begin
                        state_nxt[i] = ST_ON;
                    end else begin
                        state_nxt[i] = ST_OFF;
                    end
                end
                ST_ON: begin
                    if ((in1 && flow_db_q[i]) || !enable[i]) begin
                        state_nxt[i] = ST_OFF;
                    end else if (wd_expired[i]) begin
                        state_nxt[i] = ST_FAULT;
                    end else begin
                        state_nxt[i] = ST_ON;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault[i]) begin
                        state_nxt[i] = ST_OFF;
                    end else begin
                        state_nxt[i] = ST_FAULT;
                    end
                end
                default: state_nxt[i] = ST_OFF;
            endcase
        end
    end

    // State register, entry pulse and saturating ON-time counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            trip_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                ocnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_nxt[i];
                trip_q[i]  <= (state_q[i] == ST_OFF) && (state_nxt[i] == ST_ON);
                if (state_nxt[i] == ST_ON) begin
                    if (state_q[i] != ST_ON) begin
                        ocnt_q[i] <= '0;
                    end else if (ocnt_q[i] != OCNT_SAT) begin
                        ocnt_q[i] <= ocnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Per-channel status decoded straight from the state registers.
    always_comb begin
        state_on = '0;
        fault    = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_on[i] = (state_q[i] == ST_ON);
            fault[i]    = (state_q[i] == ST_FAULT);
        end
    end

    // Population count of channels currently ON.
    always_comb begin
        active_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_count = active_count + ACW'(state_on[i]);
        end
    end

    assign trip_pulse = trip_q;
    assign any_fault  = |fault;

endmodule

// File: tb/tb_water_safety_multizone_ctrl.sv
// Bench for water_safety_multizone_ctrl: a behavioural model predicts the
// outputs for every clock, pushes them to a scoreboard queue, and each sample
// taken after the edge is popped and compared. Directed checks mark the key
// scenario points.

module tb_water_safety_multizone_ctrl;

    localparam int N_CH   = 4;
    localparam int DEB    = 3;
    localparam int MAX_ON = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in1;
    logic [3:0] in2;
    logic [3:0] enable;
    logic [3:0] clear_fault;
    logic [3:0] state_on;
    logic [3:0] fault;
    logic [3:0] trip_pulse;
    logic       any_fault;
    logic [2:0] active_count;

    typedef struct packed {
        logic [3:0] on;
        logic [3:0] flt;
        logic [3:0] trip;
        logic       any;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    // model state: 0 = off, 1 = on, 2 = fault; age = cycles already spent ON
    int m_st  [4];
    int m_db  [4];
    int m_dc  [4];
    int m_age [4];
    int m_trip[4];

    water_safety_multizone_ctrl #(
        .N_CH        (N_CH),
        .DEBOUNCE_CYC(DEB),
        .MAX_ON_CYC  (MAX_ON)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in1         (in1),
        .in2         (in2),
        .enable      (enable),
        .clear_fault (clear_fault),
        .state_on    (state_on),
        .fault       (fault),
        .trip_pulse  (trip_pulse),
        .any_fault   (any_fault),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int ns;
        for (int i = 0; i < N_CH; i++) begin
            if (reset) begin
                m_st[i] = 0; m_db[i] = 0; m_dc[i] = 0; m_age[i] = 0; m_trip[i] = 0;
            end else begin
                ns = m_st[i];
                case (m_st[i])
                    0: if (enable[i] && !in1 && m_db[i] == 1) ns = 1;
                    1: begin
                        if ((in1 && m_db[i] == 1) || !enable[i]) ns = 0;
                        else if (m_age[i] == MAX_ON) ns = 2;
                    end
                    2: if (clear_fault[i]) ns = 0;
                    default: ns = 0;
                endcase
                if (ns == 1 && m_st[i] != 1) m_age[i] = 1;
                else if (ns == 1) m_age[i] = m_age[i] + 1;
                m_trip[i] = (m_st[i] == 0 && ns == 1) ? 1 : 0;
                if (int'(in2[i]) == m_db[i]) begin
                    m_dc[i] = 0;
                end else begin
                    m_dc[i] = m_dc[i] + 1;
                    if (m_dc[i] == DEB) begin
                        m_db[i] = 1 - m_db[i];
                        m_dc[i] = 0;
                    end
                end
                m_st[i] = ns;
            end
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        for (int i = 0; i < N_CH; i++) begin
            e.on[i]   = (m_st[i] == 1);
            e.flt[i]  = (m_st[i] == 2);
            e.trip[i] = (m_trip[i] == 1);
            if (m_st[i] == 1) e.cnt = e.cnt + 3'd1;
        end
        e.any = |e.flt;
        return e;
    endfunction

    // One clock: predict, push, clock, sample 1 time unit after the edge, pop, compare.
    task automatic step();
        exp_t e;
        model_step();
        sb_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            check("sb_state_on",     32'(state_on),     32'(e.on));
            check("sb_fault",        32'(fault),        32'(e.flt));
            check("sb_trip_pulse",   32'(trip_pulse),   32'(e.trip));
            check("sb_any_fault",    32'(any_fault),    32'(e.any));
            check("sb_active_count", 32'(active_count), 32'(e.cnt));
        end
    endtask

    initial begin
        int hi;
        logic seen;

        // reset with every input high
        reset = 1'b1; in1 = 1'b1; in2 = 4'hF; enable = 4'hF; clear_fault = 4'hF;
        step();
        step();
        check("rst_state_on", 32'(state_on), 32'(0));
        check("rst_fault", 32'(fault), 32'(0));
        check("rst_trip", 32'(trip_pulse), 32'(0));
        check("rst_active", 32'(active_count), 32'(0));

        // trip on channel 0
        reset = 1'b0; clear_fault = 4'h0; in1 = 1'b0; enable = 4'hF; in2 = 4'b0001;
        step(); step(); step();
        check("db_hold_e3", 32'(state_on), 32'(0));
        step();
        check("trip_on_e4", 32'(state_on), 32'(4'b0001));
        check("trip_pulse_e4", 32'(trip_pulse), 32'(4'b0001));
        check("trip_active_e4", 32'(active_count), 32'(1));
        step();
        check("trip_once_e5", 32'(trip_pulse), 32'(0));

        // exit on the watchdog edge: OFF condition wins
        for (int k = 0; k < 6; k++) step();
        in1 = 1'b1;
        step();
        check("exit_wd_on", 32'(state_on[0]), 32'(0));
        check("exit_wd_fault", 32'(fault[0]), 32'(0));

        // watchdog expiry: ON exactly MAX_ON cycles, then sticky fault
        in1 = 1'b0;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (state_on[0]) hi++;
        end
        check("wd_on_cycles", 32'(hi), 32'(MAX_ON));
        check("wd_fault", 32'(fault[0]), 32'(1));
        check("wd_any_fault", 32'(any_fault), 32'(1));
        enable = 4'b1110;
        step(); step();
        check("fault_sticky_en0", 32'(fault[0]), 32'(1));
        clear_fault = 4'b0001; enable = 4'hF;
        step();
        check("clr_fault", 32'(fault[0]), 32'(0));
        check("clr_off", 32'(state_on[0]), 32'(0));
        check("clr_no_pulse", 32'(trip_pulse[0]), 32'(0));
        clear_fault = 4'h0;
        step();
        check("retrip_on", 32'(state_on[0]), 32'(1));
        check("retrip_pulse", 32'(trip_pulse[0]), 32'(1));

        // glitch on channel 1 shorter than the debounce window
        seen = 1'b0;
        in2 = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            step();
            seen = seen | state_on[1] | trip_pulse[1];
        end
        in2 = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            seen = seen | state_on[1] | trip_pulse[1];
        end
        check("glitch_reject", 32'(seen), 32'(0));

        // all channels ON together, then drop enable[2]
        in1 = 1'b1; clear_fault = 4'hF; in2 = 4'hF;
        for (int k = 0; k < 4; k++) step();
        check("multi_all_off", 32'(state_on | fault), 32'(0));
        clear_fault = 4'h0; in1 = 1'b0;
        step();
        check("multi_all_on", 32'(state_on), 32'(4'hF));
        check("multi_count4", 32'(active_count), 32'(4));
        enable = 4'b1011;
        step();
        check("en_drop_on", 32'(state_on), 32'(4'b1011));
        check("en_drop_count", 32'(active_count), 32'(3));
        check("en_drop_fault", 32'(fault), 32'(0));

        // reset while channels are faulted
        for (int k = 0; k < 8; k++) step();
        check("mid_fault", 32'(fault), 32'(4'b1011));
        reset = 1'b1;
        step();
        check("rst_mid_fault", 32'(fault), 32'(0));
        check("rst_mid_any", 32'(any_fault), 32'(0));
        check("rst_mid_on", 32'(state_on), 32'(0));
        reset = 1'b0; enable = 4'hF; in2 = 4'hF; in1 = 1'b0;
        step(); step(); step();
        check("post_rst_db_e3", 32'(state_on), 32'(0));
        step();
        check("post_rst_on_e4", 32'(state_on), 32'(4'hF));
        check("post_rst_pulse", 32'(trip_pulse), 32'(4'hF));

        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
